// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file.
//   DEF_XLEN / DEF_NREGS / DEF_NRD / DEF_NWR : default geometry
//   DEF_AW   : register address width derived from DEF_NREGS
//   PC_IDX   : register index that aliases the PC+8 value
//   reg_addr_t / word_t : address and data word types at default geometry
package regfile_pkg;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_NREGS = 16;
  localparam int DEF_NRD   = 3;
  localparam int DEF_NWR   = 2;
  localparam int DEF_AW    = $clog2(DEF_NREGS);
  localparam int PC_IDX    = DEF_NREGS - 1;

  typedef logic [DEF_AW-1:0]   reg_addr_t;
  typedef logic [DEF_XLEN-1:0] word_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard and read-port hazard detection.
// Ports:
//   i_clk, i_reset     : clock, asynchronous active-high reset
//   i_we, i_wa         : writeback enables/addresses (clear busy)
//   i_iss_valid,i_iss_rd : issue of a producer for i_iss_rd (sets busy)
//   i_flush            : clear every busy bit
//   i_ra, i_byp_hit    : read addresses and per-port same-cycle bypass hits
//   o_busy             : registered busy vector
//   o_hazard, o_any_hazard : combinational per-port hazard and its OR
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = DEF_NREGS,
  parameter int NRD   = DEF_NRD,
  parameter int NWR   = DEF_NWR,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [NWR-1:0]          i_we,
  input  logic [NWR-1:0][AW-1:0]  i_wa,
  input  logic                    i_iss_valid,
  input  logic [AW-1:0]           i_iss_rd,
  input  logic                    i_flush,
  input  logic [NRD-1:0][AW-1:0]  i_ra,
  input  logic [NRD-1:0]          i_byp_hit,
  output logic [NREGS-1:0]        o_busy,
  output logic [NRD-1:0]          o_hazard,
  output logic                    o_any_hazard
);

  localparam logic [AW-1:0] PC_A = AW'(NREGS - 1);

  logic [NREGS-1:0] w_wb_clr;

  always_comb begin
    w_wb_clr = '0;
    for (int r = 0; r < NREGS; r++) begin
      for (int i = 0; i < NWR; i++) begin
        if (i_we[i] && (i_wa[i] == AW'(r))) w_wb_clr[r] = 1'b1;
      end
    end
  end

  // Priority: flush > issue set > writeback clear > hold. A new producer
  // supersedes the older one being written back in the same cycle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_busy <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (i_flush)
          o_busy[r] <= 1'b0;
        else if (i_iss_valid && (i_iss_rd == AW'(r)) && (r != NREGS - 1))
          o_busy[r] <= 1'b1;
        else if (w_wb_clr[r])
          o_busy[r] <= 1'b0;
      end
    end
  end

  // PC alias and out-of-range indices never raise a hazard; a bypass hit
  // supplies the value this cycle so no stall is needed.
  always_comb begin
    o_hazard = '0;
    for (int j = 0; j < NRD; j++) begin
      if ((i_ra[j] < PC_A) && !i_byp_hit[j]) o_hazard[j] = o_busy[i_ra[j]];
    end
  end

  assign o_any_hazard = |o_hazard;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with write-first bypass, PC alias
// on the top index and a busy scoreboard for hazard detection.
// Ports:
//   i_clk, i_reset       : clock, asynchronous active-high reset
//   i_we, i_wa, i_wd     : NWR write ports (highest index wins on collision)
//   i_ra / o_rd          : NRD combinational read ports
//   i_pc_plus8           : value returned for reads of index NREGS-1
//   i_iss_valid, i_iss_rd: issuing instruction and its destination
//   i_flush              : clear all busy bits
//   o_busy               : registered scoreboard state
//   o_hazard, o_any_hazard : per-port hazard and its OR
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int NREGS = DEF_NREGS,
  parameter int NRD   = DEF_NRD,
  parameter int NWR   = DEF_NWR,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [NWR-1:0]           i_we,
  input  logic [NWR-1:0][AW-1:0]   i_wa,
  input  logic [NWR-1:0][XLEN-1:0] i_wd,
  input  logic [NRD-1:0][AW-1:0]   i_ra,
  output logic [NRD-1:0][XLEN-1:0] o_rd,
  input  logic [XLEN-1:0]          i_pc_plus8,
  input  logic                     i_iss_valid,
  input  logic [AW-1:0]            i_iss_rd,
  input  logic                     i_flush,
  output logic [NREGS-1:0]         o_busy,
  output logic [NRD-1:0]           o_hazard,
  output logic                     o_any_hazard
);

  localparam logic [AW-1:0] PC_A = AW'(NREGS - 1);

  logic [XLEN-1:0] r_rf [NREGS-1:0];
  logic [NRD-1:0]  w_byp_hit;

  // Ascending loop: a later (higher-index) port overrides on collision.
  // Addresses at or above the PC index are never stored.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int r = 0; r < NREGS; r++) r_rf[r] <= '0;
    end else begin
      for (int i = 0; i < NWR; i++) begin
        if (i_we[i] && (i_wa[i] < PC_A)) r_rf[i_wa[i]] <= i_wd[i];
      end
    end
  end

  // PC alias first, then bypass (highest port wins), then storage.
  // Out-of-range indices read zero and never bypass.
  always_comb begin
    w_byp_hit = '0;
    o_rd      = '0;
    for (int j = 0; j < NRD; j++) begin
      if (i_ra[j] == PC_A) begin
        o_rd[j] = i_pc_plus8;
      end else if (i_ra[j] < PC_A) begin
        o_rd[j] = r_rf[i_ra[j]];
        for (int i = 0; i < NWR; i++) begin
          if (i_we[i] && (i_wa[i] == i_ra[j])) begin
            o_rd[j]      = i_wd[i];
            w_byp_hit[j] = 1'b1;
          end
        end
      end
    end
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD),
    .NWR   (NWR),
    .AW    (AW)
  ) u_scoreboard (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_we         (i_we),
    .i_wa         (i_wa),
    .i_iss_valid  (i_iss_valid),
    .i_iss_rd     (i_iss_rd),
    .i_flush      (i_flush),
    .i_ra         (i_ra),
    .i_byp_hit    (w_byp_hit),
    .o_busy       (o_busy),
    .o_hazard     (o_hazard),
    .o_any_hazard (o_any_hazard)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: expectations are queued when stimulus is
// driven and popped when the corresponding output is sampled.
module tb_regfile_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 16;
  localparam int NRD   = 3;
  localparam int NWR   = 2;
  localparam int AW    = 4;

  logic                     clk;
  logic                     reset;
  logic [NWR-1:0]           we;
  logic [NWR-1:0][AW-1:0]   wa;
  logic [NWR-1:0][XLEN-1:0] wd;
  logic [NRD-1:0][AW-1:0]   ra;
  logic [NRD-1:0][XLEN-1:0] rd;
  logic [XLEN-1:0]          pc_plus8;
  logic                     iss_valid;
  logic [AW-1:0]            iss_rd;
  logic                     flush;
  logic [NREGS-1:0]         busy;
  logic [NRD-1:0]           hazard;
  logic                     any_hazard;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   applied;
  int   miscompares;

  regfile_mp #(
    .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .AW(AW)
  ) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_we         (we),
    .i_wa         (wa),
    .i_wd         (wd),
    .i_ra         (ra),
    .o_rd         (rd),
    .i_pc_plus8   (pc_plus8),
    .i_iss_valid  (iss_valid),
    .i_iss_rd     (iss_rd),
    .i_flush      (flush),
    .o_busy       (busy),
    .o_hazard     (hazard),
    .o_any_hazard (any_hazard)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic exp_push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    applied++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL scoreboard_empty observed=%h expected=<queued value>", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val)
      else begin
        miscompares++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic idle_inputs();
    we        = '0;
    wa        = '0;
    wd        = '0;
    iss_valid = 1'b0;
    iss_rd    = '0;
    flush     = 1'b0;
  endtask

  initial begin
    applied     = 0;
    miscompares = 0;
    idle_inputs();
    ra       = '0;
    pc_plus8 = 32'h108;
    reset    = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // 1: reset state on every index
    for (int r = 0; r < NREGS; r++) begin
      @(negedge clk);
      ra[0] = AW'(r);
      exp_push($sformatf("reset_rd_r%0d", r), (r == NREGS - 1) ? 32'h108 : 32'h0);
      #1 check(rd[0]);
    end
    exp_push("reset_busy", 32'h0);
    exp_push("reset_any_hazard", 32'h0);
    check(32'(busy));
    check(32'(any_hazard));

    // 2: same-cycle bypass, then committed value
    @(negedge clk);
    we[0] = 1'b1; wa[0] = 4'd3; wd[0] = 32'hDEADBEEF; ra[0] = 4'd3;
    exp_push("bypass_r3", 32'hDEADBEEF);
    #1 check(rd[0]);
    @(negedge clk);
    idle_inputs();
    exp_push("commit_r3", 32'hDEADBEEF);
    #1 check(rd[0]);

    // 3: write collision, highest port wins; PC writes ignored
    @(negedge clk);
    we = 2'b11; wa[0] = 4'd5; wa[1] = 4'd5; wd[0] = 32'h11; wd[1] = 32'h22; ra[1] = 4'd5;
    exp_push("collide_bypass_r5", 32'h22);
    #1 check(rd[1]);
    @(negedge clk);
    idle_inputs();
    exp_push("collide_commit_r5", 32'h22);
    #1 check(rd[1]);
    @(negedge clk);
    we[0] = 1'b1; wa[0] = 4'd15; wd[0] = 32'h55; ra[2] = 4'd15;
    exp_push("pc_write_bypass_blocked", 32'h108);
    #1 check(rd[2]);
    @(negedge clk);
    idle_inputs();
    pc_plus8 = 32'h200;
    exp_push("pc_alias_after_write", 32'h200);
    #1 check(rd[2]);
    pc_plus8 = 32'h108;

    // 4: issue sets busy, hazard, writeback resolves in the same cycle
    @(negedge clk);
    iss_valid = 1'b1; iss_rd = 4'd7;
    exp_push("busy_before_edge", 32'h0);
    #1 check(32'(busy));
    @(negedge clk);
    idle_inputs();
    ra[1] = 4'd7;
    exp_push("busy_r7", 32'h0080);
    exp_push("hazard_r7", 32'h2);
    exp_push("any_hazard_r7", 32'h1);
    #1 check(32'(busy));
    check(32'(hazard));
    check(32'(any_hazard));
    we[0] = 1'b1; wa[0] = 4'd7; wd[0] = 32'h77;
    exp_push("hazard_resolved_wb", 32'h0);
    exp_push("any_hazard_resolved_wb", 32'h0);
    exp_push("rd_bypass_r7", 32'h77);
    exp_push("busy_held_until_edge", 32'h0080);
    #1 check(32'(hazard));
    check(32'(any_hazard));
    check(rd[1]);
    check(32'(busy));
    @(negedge clk);
    idle_inputs();
    exp_push("busy_cleared_r7", 32'h0);
    exp_push("rd_commit_r7", 32'h77);
    #1 check(32'(busy));
    check(rd[1]);

    // 5: issue beats writeback clear; flush beats issue; PC issue ignored
    @(negedge clk);
    iss_valid = 1'b1; iss_rd = 4'd4;
    we[0] = 1'b1; wa[0] = 4'd4; wd[0] = 32'h44;
    @(negedge clk);
    idle_inputs();
    ra[0] = 4'd4;
    exp_push("busy_set_beats_clear", 32'h0010);
    exp_push("hazard_r4", 32'h1);
    #1 check(32'(busy));
    check(32'(hazard));
    iss_valid = 1'b1; iss_rd = 4'd4; flush = 1'b1;
    @(negedge clk);
    idle_inputs();
    exp_push("flush_beats_issue", 32'h0);
    #1 check(32'(busy));
    iss_valid = 1'b1; iss_rd = 4'd15;
    @(negedge clk);
    idle_inputs();
    exp_push("issue_pc_no_busy", 32'h0);
    #1 check(32'(busy));

    // 6: async reset between edges clears contents and busy at once
    @(negedge clk);
    we[0] = 1'b1; wa[0] = 4'd2; wd[0] = 32'hA2;
    iss_valid = 1'b1; iss_rd = 4'd2;
    @(negedge clk);
    idle_inputs();
    iss_valid = 1'b1; iss_rd = 4'd9;
    @(negedge clk);
    idle_inputs();
    ra[0] = 4'd2; ra[1] = 4'd9; ra[2] = 4'd0;
    exp_push("busy_r2_r9", 32'h0204);
    exp_push("hazard_r2_r9", 32'h3);
    exp_push("rd_r2_before_reset", 32'hA2);
    #1 check(32'(busy));
    check(32'(hazard));
    check(rd[0]);
    #1 reset = 1'b1;
    exp_push("async_reset_busy", 32'h0);
    exp_push("async_reset_rd_r2", 32'h0);
    exp_push("async_reset_hazard", 32'h0);
    exp_push("async_reset_any_hazard", 32'h0);
    #1 check(32'(busy));
    check(rd[0]);
    check(32'(hazard));
    check(32'(any_hazard));
    reset = 1'b0;
    @(negedge clk);
    we[0] = 1'b1; wa[0] = 4'd2; wd[0] = 32'h5A;
    @(negedge clk);
    idle_inputs();
    exp_push("first_write_after_reset", 32'h5A);
    #1 check(rd[0]);

    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL leftover_expectations observed=%0d expected=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
